mips_multicycle_ctrl: RTL and testbench

//  Multicycle FSM sequencer for the MIPS32 datapath: drives register, memory, ALU and PC controls per state.

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_perf_cnt.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS32 multicycle controller: FSM states,
// opcode/func constants, ALU operation codes and datapath mux select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/mips_perf_cnt.sv
// Retired-instruction and memory-stall counters for the multicycle controller.
// Both clear on rst and wrap naturally at 2^CNT_W.
module mips_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_done,
  input  logic             stall,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q + (instr_done ? CNT_W'(1) : CNT_W'(0));
    stall_cnt_d = stall_cnt_q + (stall ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control FSM (Moore, with pc_en/ir_write gated by mem_ready/zero).
// Define PERF_CNT_EN to add the instr_cnt/stall_cnt performance counter outputs.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t state_q, state_d;
  logic   is_rtype_q, is_rtype_d;
  logic   is_bne_q, is_bne_d;
  logic   is_jal_q, is_jal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      is_rtype_q <= 1'b0;
      is_bne_q   <= 1'b0;
      is_jal_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rtype_q <= is_rtype_d;
      is_bne_q   <= is_bne_d;
      is_jal_q   <= is_jal_d;
    end
  end

  // Everything defaults to 0 so that rst forces strobes off and selects to 0.
  always_comb begin
    state_d    = state_q;
    is_rtype_d = is_rtype_q;
    is_bne_d   = is_bne_q;
    is_jal_d   = is_jal_q;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;

    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_BOFF;
          is_rtype_d = (opcode == OP_RTYPE);
          is_bne_d   = (opcode == OP_BNE);
          is_jal_d   = (opcode == OP_JAL);
          case (opcode)
            OP_LW, OP_SW:              state_d = S_MEM_ADDR;
            OP_RTYPE:                  state_d = (func == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_SLTI: state_d = S_EXEC_I;
            OP_BEQ, OP_BNE:            state_d = S_BRANCH;
            OP_J, OP_JAL:              state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
          state_d    = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNC;
          state_d   = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          case (opcode)
            OP_ANDI: alu_op = ALU_AND;
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
          state_d = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = is_rtype_q ? REGDST_RD : REGDST_RT;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = zero ^ is_bne_q;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
          if (is_jal_q) begin
            reg_write  = 1'b1;
            reg_dst    = REGDST_RA;
            mem_to_reg = M2R_PC;
          end
          state_d = S_FETCH;
        end
        S_JR: begin
          pc_src  = PCSRC_RS;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic instr_done, stall;

  // Illegal ops return to FETCH straight from DECODE and are not retired.
  assign instr_done = !rst && (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_op;
  assign stall      = !rst && !mem_ready &&
                      ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR));

  mips_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .instr_done (instr_done),
    .stall      (stall),
    .instr_cnt  (instr_cnt),
    .stall_cnt  (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected control vectors are
// queued by the driver and compared by an independent monitor on the falling edge.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    string lbl;
    outs_t exp;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_op;
`ifdef PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op)
`ifdef PERF_CNT_EN
    ,
    .instr_cnt  (instr_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  item_t q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    at_edge = 1'b0;
  bit    drive_done = 1'b0;

  // Expected control vectors, written out by hand from the state descriptions.
  function automatic outs_t e_zero();
    return '0;
  endfunction
  function automatic outs_t e_fetch(bit rdy);
    outs_t e = '0;
    e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy;
    return e;
  endfunction
  function automatic outs_t e_decode(bit ill);
    outs_t e = '0;
    e.alu_src_b = 2'b11; e.illegal_op = ill;
    return e;
  endfunction
  function automatic outs_t e_maddr();
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction
  function automatic outs_t e_mrd();
    outs_t e = '0;
    e.i_or_d = 1'b1; e.mem_read = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_mwr();
    outs_t e = '0;
    e.i_or_d = 1'b1; e.mem_write = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_mwb();
    outs_t e = '0;
    e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
    return e;
  endfunction
  function automatic outs_t e_execr();
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_op = 3'b010;
    return e;
  endfunction
  function automatic outs_t e_execi(logic [2:0] op);
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = op;
    return e;
  endfunction
  function automatic outs_t e_aluwb(bit r);
    outs_t e = '0;
    e.reg_write = 1'b1; e.reg_dst = r ? 2'b01 : 2'b00;
    return e;
  endfunction
  function automatic outs_t e_branch(bit en);
    outs_t e = '0;
    e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_en = en;
    return e;
  endfunction
  function automatic outs_t e_jump(bit jal);
    outs_t e = '0;
    e.pc_src = 2'b10; e.pc_en = 1'b1;
    if (jal) begin
      e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
    end
    return e;
  endfunction
  function automatic outs_t e_jr();
    outs_t e = '0;
    e.pc_src = 2'b11; e.pc_en = 1'b1;
    return e;
  endfunction

  task automatic cyc(input string lbl, input bit r, input logic [5:0] op, input logic [5:0] fn,
                     input bit z, input bit rdy, input outs_t e);
    if (!at_edge) @(posedge clk);
    at_edge = 1'b0;
    #2;
    rst = r; opcode = op; func = fn; zero = z; mem_ready = rdy;
    q.push_back('{lbl, e});
  endtask

`ifdef PERF_CNT_EN
  task automatic perf_chk(input string lbl, input int ei, input int es);
    @(posedge clk);
    #1;
    at_edge = 1'b1;
    n_checks++;
    if (instr_cnt == 32'(ei) && stall_cnt == 32'(es)) n_pass++;
    else $display("FAIL %s: instr_cnt=%0d stall_cnt=%0d, want %0d/%0d", lbl, instr_cnt, stall_cnt, ei, es);
  endtask
`endif

  // Monitor: compare the queued expectation against the DUT every falling edge.
  initial begin
    outs_t act;
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
        n_checks++;
        if (act === it.exp) n_pass++;
        else $display("FAIL %s: got %05h want %05h", it.lbl, act, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, SLTI = 6'b001010;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADD_FN = 6'b100000, JR_FN = 6'b001000;

  initial begin
    // reset: strobes forced low even with mem_ready high
    cyc("rst0", 1, LW, 0, 1, 1, e_zero());
    cyc("rst1", 1, LW, 0, 1, 1, e_zero());
`ifdef PERF_CNT_EN
    perf_chk("perf_reset", 0, 0);
`endif
    // add: F,D,EXEC_R,ALU_WB
    cyc("add_f", 0, R, ADD_FN, 0, 1, e_fetch(1));
    cyc("add_d", 0, R, ADD_FN, 0, 1, e_decode(0));
    cyc("add_x", 0, R, ADD_FN, 0, 1, e_execr());
    cyc("add_wb", 0, R, ADD_FN, 0, 1, e_aluwb(1));
    // lw with three wait cycles in MEM_RD; mem_ready low in MEM_ADDR is ignored
    cyc("lw_f", 0, LW, 0, 0, 1, e_fetch(1));
    cyc("lw_d", 0, LW, 0, 0, 1, e_decode(0));
    cyc("lw_a", 0, LW, 0, 0, 0, e_maddr());
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 0, LW, 0, 0, 0, e_mrd());
    cyc("lw_rd", 0, LW, 0, 0, 1, e_mrd());
    cyc("lw_wb", 0, LW, 0, 0, 1, e_mwb());
`ifdef PERF_CNT_EN
    perf_chk("perf_lw", 2, 3);
`endif
    // sw with one fetch wait cycle
    cyc("sw_f_wait", 0, SW, 0, 0, 0, e_fetch(0));
    cyc("sw_f", 0, SW, 0, 0, 1, e_fetch(1));
    cyc("sw_d", 0, SW, 0, 0, 1, e_decode(0));
    cyc("sw_a", 0, SW, 0, 0, 1, e_maddr());
    cyc("sw_wr", 0, SW, 0, 0, 1, e_mwr());
    // immediate ALU ops
    cyc("addi_f", 0, ADDI, 0, 0, 1, e_fetch(1));
    cyc("addi_d", 0, ADDI, 0, 0, 1, e_decode(0));
    cyc("addi_x", 0, ADDI, 0, 0, 1, e_execi(3'b000));
    cyc("addi_wb", 0, ADDI, 0, 0, 1, e_aluwb(0));
    cyc("andi_f", 0, ANDI, 0, 0, 1, e_fetch(1));
    cyc("andi_d", 0, ANDI, 0, 0, 1, e_decode(0));
    cyc("andi_x", 0, ANDI, 0, 0, 1, e_execi(3'b011));
    cyc("andi_wb", 0, ANDI, 0, 0, 1, e_aluwb(0));
    cyc("slti_f", 0, SLTI, 0, 0, 1, e_fetch(1));
    cyc("slti_d", 0, SLTI, 0, 0, 1, e_decode(0));
    cyc("slti_x", 0, SLTI, 0, 0, 1, e_execi(3'b100));
    cyc("slti_wb", 0, SLTI, 0, 0, 1, e_aluwb(0));
    // branches: all four zero/opcode combinations
    cyc("beq1_f", 0, BEQ, 0, 1, 1, e_fetch(1));
    cyc("beq1_d", 0, BEQ, 0, 1, 1, e_decode(0));
    cyc("beq1_br", 0, BEQ, 0, 1, 1, e_branch(1));
    cyc("beq0_f", 0, BEQ, 0, 0, 1, e_fetch(1));
    cyc("beq0_d", 0, BEQ, 0, 0, 1, e_decode(0));
    cyc("beq0_br", 0, BEQ, 0, 0, 1, e_branch(0));
    cyc("bne1_f", 0, BNE, 0, 1, 1, e_fetch(1));
    cyc("bne1_d", 0, BNE, 0, 1, 1, e_decode(0));
    cyc("bne1_br", 0, BNE, 0, 1, 1, e_branch(0));
    cyc("bne0_f", 0, BNE, 0, 0, 1, e_fetch(1));
    cyc("bne0_d", 0, BNE, 0, 0, 1, e_decode(0));
    cyc("bne0_br", 0, BNE, 0, 0, 1, e_branch(1));
    // jumps
    cyc("j_f", 0, J, 0, 0, 1, e_fetch(1));
    cyc("j_d", 0, J, 0, 0, 1, e_decode(0));
    cyc("j_j", 0, J, 0, 0, 1, e_jump(0));
    cyc("jal_f", 0, JAL, 0, 0, 1, e_fetch(1));
    cyc("jal_d", 0, JAL, 0, 0, 1, e_decode(0));
    cyc("jal_j", 0, JAL, 0, 0, 1, e_jump(1));
    cyc("jr_f", 0, R, JR_FN, 0, 1, e_fetch(1));
    cyc("jr_d", 0, R, JR_FN, 0, 1, e_decode(0));
    cyc("jr_j", 0, R, JR_FN, 0, 1, e_jr());
    // illegal opcode: one-cycle pulse, straight back to FETCH
    cyc("ill_f", 0, 6'b111111, 0, 0, 1, e_fetch(1));
    cyc("ill_d", 0, 6'b111111, 0, 0, 1, e_decode(1));
    cyc("ill_next_f", 0, 6'b111111, 0, 0, 0, e_fetch(0));
    // reset during MEM_WR aborts the store
    cyc("swr_f", 0, SW, 0, 0, 1, e_fetch(1));
    cyc("swr_d", 0, SW, 0, 0, 1, e_decode(0));
    cyc("swr_a", 0, SW, 0, 0, 1, e_maddr());
    cyc("swr_rst", 1, SW, 0, 0, 1, e_zero());
    cyc("swr_after_f", 0, R, ADD_FN, 0, 1, e_fetch(1));
    cyc("swr_after_d", 0, R, ADD_FN, 0, 1, e_decode(0));
    cyc("swr_after_x", 0, R, ADD_FN, 0, 1, e_execr());
    cyc("swr_after_wb", 0, R, ADD_FN, 0, 1, e_aluwb(1));
    drive_done = 1'b1;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
